// File: rtl/fetch_pkg.sv
// Shared defaults and queue-entry layout for the instruction prefetch queue.
package fetch_pkg;

  localparam int FETCH_WORD_SIZE  = 16;
  localparam int FETCH_ADDR_WIDTH = 16;
  localparam int FETCH_DEPTH      = 4;
  localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_PC = '0;

  // Entry layout at default widths: PC in the upper bits, word in the lower bits.
  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_WORD_SIZE-1:0]  word;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bundle: control inputs, instruction-memory request/response and decode handshake.
interface fetch_prefetch_queue_if
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE  = FETCH_WORD_SIZE,
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int DEPTH      = FETCH_DEPTH
);
  logic                       fetch_enable;
  logic                       redirect_valid;
  logic [ADDR_WIDTH-1:0]      redirect_pc;
  logic                       mem_req_valid;
  logic [ADDR_WIDTH-1:0]      mem_req_addr;
  logic                       mem_req_ready;
  logic                       mem_resp_valid;
  logic [WORD_SIZE-1:0]       mem_resp_data;
  logic                       instr_valid;
  logic [WORD_SIZE-1:0]       instr;
  logic [ADDR_WIDTH-1:0]      instr_pc;
  logic                       instr_ready;
  logic [$clog2(DEPTH):0]     occupancy;

  modport master (
    input  fetch_enable, redirect_valid, redirect_pc, mem_req_ready,
           mem_resp_valid, mem_resp_data, instr_ready,
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, occupancy
  );

  modport slave (
    output fetch_enable, redirect_valid, redirect_pc, mem_req_ready,
           mem_resp_valid, mem_resp_data, instr_ready,
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, occupancy
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and count; a push is visible at the head next cycle.
// No internal backpressure: the caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetch with PC-tagged FWFT queue; response to instr_valid is 1 cycle.
// Issue stops once queued + in-flight words reach DEPTH; decode stalls the queue via instr_ready.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE  = FETCH_WORD_SIZE,
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int DEPTH      = FETCH_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(FETCH_RESET_PC)
) (
  input logic                    clock,
  input logic                    reset_n,
  fetch_prefetch_queue_if.master bus
);
  localparam int CW  = cnt_width(DEPTH);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_CNT = CW1'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [WORD_SIZE-1:0]  word;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         inflight_nxt;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         occupancy;
  logic [CW:0]           credit_used;
  logic                  active;
  logic                  req_fire;
  logic                  resp_keep;
  logic                  pop;
  entry_t                push_entry;
  entry_t                head_entry;

  // active keeps mem_req_valid low while reset is asserted without a reset->valid path.
  assign credit_used       = {1'b0, occupancy} + {1'b0, inflight};
  assign bus.mem_req_valid = active & bus.fetch_enable & ~bus.redirect_valid
                             & (credit_used < DEPTH_CNT);
  assign bus.mem_req_addr  = fetch_pc;
  assign req_fire          = bus.mem_req_valid & bus.mem_req_ready;

  assign resp_keep   = bus.mem_resp_valid & ~bus.redirect_valid & (discard == '0);
  assign push_entry  = '{pc: resp_pc, word: bus.mem_resp_data};

  assign bus.instr_valid = (occupancy != '0) & ~bus.redirect_valid;
  assign pop             = bus.instr_valid & bus.instr_ready;
  assign bus.instr       = head_entry.word;
  assign bus.instr_pc    = head_entry.pc;
  assign bus.occupancy   = occupancy;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH + WORD_SIZE)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (resp_keep),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .push_data (push_entry),
    .head_data (head_entry),
    .count     (occupancy)
  );

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire)           inflight_nxt = inflight_nxt + 1'b1;
    if (bus.mem_resp_valid) inflight_nxt = inflight_nxt - 1'b1;
  end

  // On redirect every request still outstanding after this edge belongs to the old stream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      active   <= 1'b1;
      inflight <= inflight_nxt;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
        discard  <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 1'b1;
        if (resp_keep) resp_pc <= resp_pc + 1'b1;
        else if (bus.mem_resp_valid && discard != '0) discard <= discard - 1'b1;
      end
    end
  end

endmodule
